// File: rtl/prt_slot_buffer.sv
// Packet reference table: NUM_SLOTS frame buffers with one allocating writer and
// one (optionally cut-through) reader; the final read beat or an invalidate frees a slot.

module prt_slot #(
  parameter int DATA_W    = 8,
  parameter int MAX_BYTES = 1518,
  parameter int CNT_W     = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc,
  input  logic              store,
  input  logic              close,
  input  logic              free,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [CNT_W-1:0]  rd_addr,
  output logic              valid,
  output logic              done,
  output logic [CNT_W-1:0]  cnt,
  output logic [DATA_W-1:0] rd_word
);
  localparam int AW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  logic [DATA_W-1:0] mem [MAX_BYTES];

  // alloc only ever targets an invalid slot, so it safely outranks free
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
    end else if (alloc) begin
      valid <= 1'b1;
      done  <= 1'b0;
      cnt   <= '0;
    end else if (free) begin
      valid <= 1'b0;
    end else begin
      if (store) cnt  <= cnt + CNT_W'(1);
      if (close) done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem[cnt[AW-1:0]] <= wr_data;
  end

  assign rd_word = mem[rd_addr[AW-1:0]];
endmodule

module prt_slot_buffer #(
  parameter int NUM_SLOTS   = 8,
  parameter int DATA_W      = 8,
  parameter int MAX_BYTES   = 1518,
  parameter int CUT_THROUGH = 1,
  localparam int IDX_W      = $clog2(NUM_SLOTS),
  localparam int CNT_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_start,
  output logic                 wr_slot_free,
  output logic [IDX_W-1:0]     wr_slot_id,
  output logic                 wr_busy,
  input  logic                 wr_valid,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 wr_last,
  input  logic                 rd_start,
  input  logic [IDX_W-1:0]     rd_slot,
  input  logic                 rd_ready,
  output logic                 rd_valid,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_last,
  output logic                 rd_err,
  input  logic                 inv_valid,
  input  logic [IDX_W-1:0]     inv_slot,
  output logic [NUM_SLOTS-1:0] slot_valid,
  output logic                 err_overflow
);
  logic [NUM_SLOTS-1:0]             done_arr;
  logic [NUM_SLOTS-1:0][CNT_W-1:0]  cnt_arr;
  logic [NUM_SLOTS-1:0][DATA_W-1:0] word_arr;

  logic              rd_busy;
  logic [IDX_W-1:0]  rd_idx;
  logic [CNT_W-1:0]  rd_ptr;
  logic [IDX_W-1:0]  alloc_idx;
  logic [CNT_W-1:0]  cur_cnt;
  logic              cur_done;
  logic              wr_fire, inv_hit_wr, wr_beat, wr_ovf, wr_store, wr_close;
  logic              inv_hit_rd, rd_fire, rd_done, rd_start_ok;

  // lowest-index free slot
  always_comb begin
    alloc_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (!slot_valid[i]) alloc_idx = IDX_W'(i);
  end

  assign wr_slot_free = (|(~slot_valid)) & ~wr_busy;
  assign wr_fire      = wr_start & wr_slot_free;
  assign inv_hit_wr   = inv_valid & wr_busy & (inv_slot == wr_slot_id);
  assign wr_beat      = wr_valid & wr_busy & ~inv_hit_wr;
  assign wr_ovf       = wr_beat & (cnt_arr[wr_slot_id] == CNT_W'(MAX_BYTES));
  assign wr_store     = wr_beat & ~wr_ovf;
  assign wr_close     = wr_beat & wr_last;

  assign cur_cnt  = cnt_arr[rd_idx];
  assign cur_done = done_arr[rd_idx];
  assign rd_valid = rd_busy && (rd_ptr < cur_cnt) && ((CUT_THROUGH != 0) || cur_done);
  assign rd_last  = rd_valid && cur_done && ((rd_ptr + CNT_W'(1)) == cur_cnt);
  assign rd_data  = rd_valid ? word_arr[rd_idx] : '0;

  assign inv_hit_rd  = inv_valid & rd_busy & (inv_slot == rd_idx);
  assign rd_fire     = rd_valid & rd_ready & ~inv_hit_rd;
  assign rd_done     = rd_fire & rd_last;
  // a slot invalidated this same cycle is not a legal read target
  assign rd_start_ok = rd_start & ~rd_busy & slot_valid[rd_slot] &
                       ~(inv_valid & (inv_slot == rd_slot));

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    prt_slot #(.DATA_W(DATA_W), .MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .alloc   (wr_fire  && alloc_idx  == IDX_W'(i)),
      .store   (wr_store && wr_slot_id == IDX_W'(i)),
      .close   (wr_close && wr_slot_id == IDX_W'(i)),
      .free    ((inv_valid && inv_slot == IDX_W'(i)) || (rd_done && rd_idx == IDX_W'(i))),
      .wr_data (wr_data),
      .rd_addr (rd_ptr),
      .valid   (slot_valid[i]),
      .done    (done_arr[i]),
      .cnt     (cnt_arr[i]),
      .rd_word (word_arr[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_busy    <= 1'b0;
      wr_slot_id <= '0;
    end else if (wr_fire) begin
      wr_busy    <= 1'b1;
      wr_slot_id <= alloc_idx;
    end else if (wr_busy && (inv_hit_wr || (wr_valid && wr_last))) begin
      wr_busy    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_busy <= 1'b0;
      rd_idx  <= '0;
      rd_ptr  <= '0;
    end else if (rd_start_ok) begin
      rd_busy <= 1'b1;
      rd_idx  <= rd_slot;
      rd_ptr  <= '0;
    end else if (rd_busy) begin
      if (inv_hit_rd || rd_done) rd_busy <= 1'b0;
      else if (rd_fire)          rd_ptr  <= rd_ptr + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_err       <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      rd_err       <= rd_start & ~rd_start_ok;
      err_overflow <= wr_ovf;
    end
  end
endmodule

// File: tb/tb_prt_slot_buffer.sv
// Directed bench: three instances (cut-through, store-and-forward, MAX_BYTES=4) share stimulus.
module tb_prt_slot_buffer;
  logic clk = 1'b0;
  logic rst;
  logic ws, wv, wl, rs, rr, iv;
  logic [7:0] wd;
  logic [2:0] rsl, isl;

  logic [2:0]      o_free, o_busy, o_rv, o_rl, o_rerr, o_ovf;
  logic [2:0][2:0] o_id;
  logic [2:0][7:0] o_rd, o_sv;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  prt_slot_buffer #(.NUM_SLOTS(8), .DATA_W(8), .MAX_BYTES(1518), .CUT_THROUGH(1)) u_ct (
    .clk(clk), .rst(rst), .wr_start(ws), .wr_slot_free(o_free[0]), .wr_slot_id(o_id[0]),
    .wr_busy(o_busy[0]), .wr_valid(wv), .wr_data(wd), .wr_last(wl), .rd_start(rs),
    .rd_slot(rsl), .rd_ready(rr), .rd_valid(o_rv[0]), .rd_data(o_rd[0]), .rd_last(o_rl[0]),
    .rd_err(o_rerr[0]), .inv_valid(iv), .inv_slot(isl), .slot_valid(o_sv[0]),
    .err_overflow(o_ovf[0]));

  prt_slot_buffer #(.NUM_SLOTS(8), .DATA_W(8), .MAX_BYTES(1518), .CUT_THROUGH(0)) u_sf (
    .clk(clk), .rst(rst), .wr_start(ws), .wr_slot_free(o_free[1]), .wr_slot_id(o_id[1]),
    .wr_busy(o_busy[1]), .wr_valid(wv), .wr_data(wd), .wr_last(wl), .rd_start(rs),
    .rd_slot(rsl), .rd_ready(rr), .rd_valid(o_rv[1]), .rd_data(o_rd[1]), .rd_last(o_rl[1]),
    .rd_err(o_rerr[1]), .inv_valid(iv), .inv_slot(isl), .slot_valid(o_sv[1]),
    .err_overflow(o_ovf[1]));

  prt_slot_buffer #(.NUM_SLOTS(8), .DATA_W(8), .MAX_BYTES(4), .CUT_THROUGH(1)) u_sm (
    .clk(clk), .rst(rst), .wr_start(ws), .wr_slot_free(o_free[2]), .wr_slot_id(o_id[2]),
    .wr_busy(o_busy[2]), .wr_valid(wv), .wr_data(wd), .wr_last(wl), .rd_start(rs),
    .rd_slot(rsl), .rd_ready(rr), .rd_valid(o_rv[2]), .rd_data(o_rd[2]), .rd_last(o_rl[2]),
    .rd_err(o_rerr[2]), .inv_valid(iv), .inv_slot(isl), .slot_valid(o_sv[2]),
    .err_overflow(o_ovf[2]));

  typedef struct {
    logic       ws, wv, wl, rs, rr;
    logic [7:0] wd;
    logic [2:0] rsl;
    logic       e_busy;
    logic [2:0] e_id;
    logic [7:0] e_sv;
    logic       e_rv;
    logic [7:0] e_rd;
    logic       e_rl, e_free;
  } vec_t;
  vec_t tbl [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ws = 1'b0; wv = 1'b0; wl = 1'b0; wd = 8'h00;
    rs = 1'b0; rsl = 3'd0; rr = 1'b0; iv = 1'b0; isl = 3'd0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // {busy, id, slot_valid, free} of instance d
  function automatic logic [31:0] wst(input int d);
    return 32'({o_busy[d], o_id[d], o_sv[d], o_free[d]});
  endfunction

  // {rd_valid, rd_data, rd_last} of instance d
  function automatic logic [31:0] rst3(input int d);
    return 32'({o_rv[d], o_rd[d], o_rl[d]});
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,3'd0, 1'b1,3'd0,8'h01,1'b0,8'h00,1'b0,1'b0};
    tbl[1] = '{1'b0,1'b1,1'b0,1'b0,1'b0,8'h11,3'd0, 1'b1,3'd0,8'h01,1'b0,8'h00,1'b0,1'b0};
    tbl[2] = '{1'b0,1'b1,1'b0,1'b0,1'b0,8'h22,3'd0, 1'b1,3'd0,8'h01,1'b0,8'h00,1'b0,1'b0};
    tbl[3] = '{1'b0,1'b1,1'b0,1'b0,1'b0,8'h33,3'd0, 1'b1,3'd0,8'h01,1'b0,8'h00,1'b0,1'b0};
    tbl[4] = '{1'b0,1'b1,1'b1,1'b0,1'b0,8'h44,3'd0, 1'b0,3'd0,8'h01,1'b0,8'h00,1'b0,1'b1};
    tbl[5] = '{1'b0,1'b0,1'b0,1'b1,1'b0,8'h00,3'd0, 1'b0,3'd0,8'h01,1'b1,8'h11,1'b0,1'b1};
    tbl[6] = '{1'b0,1'b0,1'b0,1'b0,1'b1,8'h00,3'd0, 1'b0,3'd0,8'h01,1'b1,8'h22,1'b0,1'b1};
    tbl[7] = '{1'b0,1'b0,1'b0,1'b0,1'b1,8'h00,3'd0, 1'b0,3'd0,8'h01,1'b1,8'h33,1'b0,1'b1};
    tbl[8] = '{1'b0,1'b0,1'b0,1'b0,1'b1,8'h00,3'd0, 1'b0,3'd0,8'h01,1'b1,8'h44,1'b1,1'b1};
    tbl[9] = '{1'b0,1'b0,1'b0,1'b0,1'b1,8'h00,3'd0, 1'b0,3'd0,8'h00,1'b0,8'h00,1'b0,1'b1};

    // reset state on every instance
    do_reset();
    for (int d = 0; d < 3; d++)
      chk($sformatf("reset_outputs_%0d", d),
          32'({o_free[d], o_id[d], o_busy[d], o_rv[d], o_rd[d], o_rl[d], o_rerr[d], o_sv[d], o_ovf[d]}),
          32'({1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0}));

    // basic 4-word frame write and read-back
    for (int i = 0; i < 10; i++) begin
      ws = tbl[i].ws; wv = tbl[i].wv; wl = tbl[i].wl; wd = tbl[i].wd;
      rs = tbl[i].rs; rsl = tbl[i].rsl; rr = tbl[i].rr;
      step();
      chk($sformatf("vec%0d", i),
          32'({o_busy[0], o_id[0], o_sv[0], o_rv[0], o_rd[0], o_rl[0], o_free[0]}),
          32'({tbl[i].e_busy, tbl[i].e_id, tbl[i].e_sv, tbl[i].e_rv, tbl[i].e_rd, tbl[i].e_rl, tbl[i].e_free}));
    end

    // fill all slots with 1-word frames, read slot 3, reuse it
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ws = 1'b1; step(); idle();
      chk($sformatf("fill_id%0d", i), 32'({o_busy[0], o_id[0]}), 32'({1'b1, 3'(i)}));
      wv = 1'b1; wl = 1'b1; wd = 8'(i); step(); idle();
    end
    chk("fill_full", wst(0), 32'({1'b0, 3'd7, 8'hFF, 1'b0}));
    rs = 1'b1; rsl = 3'd3; step(); idle();
    chk("fill_rd3", rst3(0), 32'({1'b1, 8'h03, 1'b1}));
    rr = 1'b1; ws = 1'b1; step(); idle();
    chk("freed_not_offered", wst(0), 32'({1'b0, 3'd7, 8'hF7, 1'b1}));
    ws = 1'b1; step(); idle();
    chk("realloc_slot3", wst(0), 32'({1'b1, 3'd3, 8'hFF, 1'b0}));

    // cut-through (u_ct) versus store-and-forward (u_sf)
    do_reset();
    ws = 1'b1; step(); idle();
    wv = 1'b1; wd = 8'hA1; step(); wd = 8'hA2; step(); idle();
    rs = 1'b1; rsl = 3'd0; rr = 1'b1; step(); rs = 1'b0;
    chk("ct_beat1", rst3(0), 32'({1'b1, 8'hA1, 1'b0}));
    chk("sf_wait1", 32'(o_rv[1]), 32'd0);
    step();
    chk("ct_beat2", rst3(0), 32'({1'b1, 8'hA2, 1'b0}));
    step();
    chk("ct_stall", 32'(o_rv[0]), 32'd0);
    for (int k = 3; k <= 6; k++) begin
      wv = 1'b1; wd = 8'(8'hA0 + k); wl = (k == 6); step(); wv = 1'b0; wl = 1'b0;
      chk($sformatf("ct_resume%0d", k), rst3(0), 32'({1'b1, 8'(8'hA0 + k), (k == 6)}));
      if (k < 6) begin
        chk($sformatf("sf_wait%0d", k), 32'(o_rv[1]), 32'd0);
        step();
        chk($sformatf("ct_stall%0d", k), 32'(o_rv[0]), 32'd0);
      end
    end
    for (int j = 1; j <= 6; j++) begin
      chk($sformatf("sf_beat%0d", j), rst3(1), 32'({1'b1, 8'(8'hA0 + j), (j == 6)}));
      if (j == 2) chk("ct_freed", 32'({o_sv[0], o_rv[0]}), 32'({8'h00, 1'b0}));
      step();
    end
    chk("sf_freed", 32'({o_sv[1], o_rv[1]}), 32'({8'h00, 1'b0}));
    idle();

    // overflow on MAX_BYTES=4 (u_sm)
    do_reset();
    ws = 1'b1; step(); idle();
    for (int k = 1; k <= 6; k++) begin
      wv = 1'b1; wd = 8'(k); wl = (k == 6); step(); idle();
      chk($sformatf("ovf_beat%0d", k), 32'(o_ovf[2]), 32'(k >= 5));
    end
    chk("ovf_closed", 32'({o_busy[2], o_sv[2]}), 32'({1'b0, 8'h01}));
    step();
    chk("ovf_pulse_end", 32'(o_ovf[2]), 32'd0);
    rs = 1'b1; rsl = 3'd0; rr = 1'b1; step();
    chk("ovf_rd1", rst3(2), 32'({1'b1, 8'h01, 1'b0}));
    step(); rs = 1'b0;
    chk("rd_err_busy", 32'({o_rerr[2], o_rv[2], o_rd[2]}), 32'({1'b1, 1'b1, 8'h02}));
    step();
    chk("ovf_rd3", 32'({o_rerr[2], o_rv[2], o_rd[2], o_rl[2]}), 32'({1'b0, 1'b1, 8'h03, 1'b0}));
    step();
    chk("ovf_rd4", rst3(2), 32'({1'b1, 8'h04, 1'b1}));
    step();
    chk("ovf_freed", 32'({o_sv[2], o_rv[2]}), 32'({8'h00, 1'b0}));
    rs = 1'b1; step(); rs = 1'b0;
    chk("rd_err_invalid", 32'(o_rerr[2]), 32'd1);
    step(); idle();
    chk("rd_err_pulse_end", 32'(o_rerr[2]), 32'd0);

    // invalidate during an open write and during a read
    do_reset();
    ws = 1'b1; step(); idle();
    wv = 1'b1; wd = 8'h55; step(); wd = 8'h66; step();
    iv = 1'b1; isl = 3'd0; wd = 8'h77; step(); idle();
    chk("inv_wr", wst(0), 32'({1'b0, 3'd0, 8'h00, 1'b1}));
    wv = 1'b1; wl = 1'b1; step(); idle();
    chk("inv_wr_ignored", wst(0), 32'({1'b0, 3'd0, 8'h00, 1'b1}));
    ws = 1'b1; step(); idle();
    chk("inv_realloc", wst(0), 32'({1'b1, 3'd0, 8'h01, 1'b0}));
    iv = 1'b1; isl = 3'd5; step(); idle();
    chk("inv_noop", wst(0), 32'({1'b1, 3'd0, 8'h01, 1'b0}));
    wv = 1'b1; wd = 8'h81; step(); wd = 8'h82; step(); wd = 8'h83; wl = 1'b1; step(); idle();
    rs = 1'b1; rsl = 3'd0; step(); idle();
    chk("inv_rd_pre", rst3(0), 32'({1'b1, 8'h81, 1'b0}));
    iv = 1'b1; isl = 3'd0; step(); idle();
    chk("inv_rd", 32'({o_rv[0], o_sv[0]}), 32'({1'b0, 8'h00}));
    ws = 1'b1; step(); idle();
    chk("inv_rd_reuse", wst(0), 32'({1'b1, 3'd0, 8'h01, 1'b0}));

    // reset mid-operation discards everything without error pulses
    wv = 1'b1; wd = 8'h99; step(); idle();
    rs = 1'b1; rsl = 3'd0; rst = 1'b1; step(); idle(); rst = 1'b0;
    chk("rst_mid", 32'({o_busy[0], o_sv[0], o_rv[0], o_rerr[0], o_ovf[0], o_free[0]}),
        32'({1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
